// File: rtl/phase_scheduler.sv
// ---------------------------------------------------------------------------
// phase_scheduler
//
// Intersection right-of-way sequencer. The main road owns the green by
// default. Side-road and pedestrian requests are latched, and the two are
// served round-robin. Every serve is bracketed by a yellow (where a road
// was green) and an all-red clearance. All phase timing counts the 1 s
// timebase strobe 'tick'.
//
// Parameters
//   MIN_GREEN  minimum green ticks for main and side roads (1..255)
//   MAX_GREEN  maximum side-road green ticks (MIN_GREEN..255)
//   YELLOW_T   yellow ticks (1..255)
//   ALL_RED_T  all-red clearance ticks (1..255)
//   WALK_T     pedestrian walk ticks (1..255)
//
// Ports
//   clk                       system clock
//   reset                     synchronous, active-high reset
//   tick                      timebase strobe, one clk wide
//   req_side                  side-road vehicle detector (level)
//   req_ped                   pedestrian button (pulse or level)
//   g_main, y_main, r_main    main-road lamps
//   g_side, y_side, r_side    side-road lamps
//   g_pedes, r_pedes          pedestrian lamps
//   ped_wait                  pedestrian request pending
//   phase                     current state code
// ---------------------------------------------------------------------------
module phase_scheduler #(
   parameter int unsigned MIN_GREEN = 10,
   parameter int unsigned MAX_GREEN = 30,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALL_RED_T = 1,
   parameter int unsigned WALK_T    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       req_side,
   input  logic       req_ped,
   output logic       g_main,
   output logic       y_main,
   output logic       r_main,
   output logic       g_side,
   output logic       y_side,
   output logic       r_side,
   output logic       g_pedes,
   output logic       r_pedes,
   output logic       ped_wait,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      CLEAR  = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      WALK   = 3'd5
   } state_t;

   // Destination of the current CLEAR phase.
   localparam logic DEST_MAIN  = 1'b0;
   localparam logic DEST_SERVE = 1'b1;

   // The counter holds ticks already seen in the state, so a state of
   // duration D exits on the tick where the counter reads D-1.
   localparam logic [7:0] MIN_LAST  = 8'(MIN_GREEN - 1);
   localparam logic [7:0] MAX_LAST  = 8'(MAX_GREEN - 1);
   localparam logic [7:0] YEL_LAST  = 8'(YELLOW_T - 1);
   localparam logic [7:0] AR_LAST   = 8'(ALL_RED_T - 1);
   localparam logic [7:0] WALK_LAST = 8'(WALK_T - 1);

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       ped_p_reg, ped_p_next;
   logic       side_p_reg, side_p_next;
   logic       dest_reg, dest_next;
   logic       last_ped_reg, last_ped_next;
   logic       enter_walk, enter_side;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= MAIN_G;
         cnt_reg      <= 8'd0;
         ped_p_reg    <= 1'b0;
         side_p_reg   <= 1'b0;
         dest_reg     <= DEST_MAIN;
         last_ped_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         ped_p_reg    <= ped_p_next;
         side_p_reg   <= side_p_next;
         dest_reg     <= dest_next;
         last_ped_reg <= last_ped_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Every transition is gated by tick.
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      dest_next     = dest_reg;
      last_ped_next = last_ped_reg;

      case (state_reg)
         MAIN_G: begin
            if (tick && (cnt_reg >= MIN_LAST) && (ped_p_reg || side_p_reg))
               state_next = MAIN_Y;
         end
         MAIN_Y: begin
            if (tick && (cnt_reg == YEL_LAST)) begin
               state_next = CLEAR;
               dest_next  = DEST_SERVE;
            end
         end
         CLEAR: begin
            if (tick && (cnt_reg == AR_LAST)) begin
               if (dest_reg == DEST_MAIN) begin
                  state_next = MAIN_G;
               end else if (ped_p_reg && (!side_p_reg || !last_ped_reg)) begin
                  // Pedestrian wins when alone, or when the side road
                  // was the most recent grant.
                  state_next    = WALK;
                  last_ped_next = 1'b1;
               end else if (side_p_reg) begin
                  state_next    = SIDE_G;
                  last_ped_next = 1'b0;
               end else begin
                  state_next = MAIN_G;
               end
            end
         end
         SIDE_G: begin
            // The live detector is used here so that the side green ends
            // as soon as the queue has cleared after the minimum.
            if (tick && ((cnt_reg == MAX_LAST) ||
                         ((cnt_reg >= MIN_LAST) && (!req_side || ped_p_reg))))
               state_next = SIDE_Y;
         end
         SIDE_Y: begin
            if (tick && (cnt_reg == YEL_LAST)) begin
               state_next = CLEAR;
               dest_next  = DEST_MAIN;
            end
         end
         WALK: begin
            if (tick && (cnt_reg == WALK_LAST)) begin
               state_next = CLEAR;
               dest_next  = DEST_MAIN;
            end
         end
         default: begin
            // Unused codes recover to the main-road green.
            state_next = MAIN_G;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pending flags and the per-state tick counter
   // ------------------------------------------------------------------
   always_comb begin
      enter_walk = (state_next == WALK)   && (state_reg != WALK);
      enter_side = (state_next == SIDE_G) && (state_reg != SIDE_G);

      // A request arriving in the grant cycle keeps the flag set.
      ped_p_next  = req_ped  | (ped_p_reg  & ~enter_walk);
      side_p_next = req_side | (side_p_reg & ~enter_side);

      if (state_next != state_reg)
         cnt_next = 8'd0;
      else if (tick && (cnt_reg != 8'hFF))
         cnt_next = cnt_reg + 8'd1;
      else
         cnt_next = cnt_reg;
   end

   // ------------------------------------------------------------------
   // Lamp decode from the registered state only
   // ------------------------------------------------------------------
   always_comb begin
      g_main  = 1'b0;
      y_main  = 1'b0;
      r_main  = 1'b0;
      g_side  = 1'b0;
      y_side  = 1'b0;
      r_side  = 1'b0;
      g_pedes = 1'b0;
      r_pedes = 1'b0;
      case (state_reg)
         MAIN_G: begin g_main = 1'b1; r_side = 1'b1; r_pedes = 1'b1; end
         MAIN_Y: begin y_main = 1'b1; r_side = 1'b1; r_pedes = 1'b1; end
         CLEAR:  begin r_main = 1'b1; r_side = 1'b1; r_pedes = 1'b1; end
         SIDE_G: begin r_main = 1'b1; g_side = 1'b1; r_pedes = 1'b1; end
         SIDE_Y: begin r_main = 1'b1; y_side = 1'b1; r_pedes = 1'b1; end
         WALK:   begin r_main = 1'b1; r_side = 1'b1; g_pedes = 1'b1; end
         // Unused codes show all red for the single cycle they can exist.
         default: begin r_main = 1'b1; r_side = 1'b1; r_pedes = 1'b1; end
      endcase
   end

   assign ped_wait = ped_p_reg;
   assign phase    = state_reg;

endmodule

// File: tb/tb_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_phase_scheduler
//
// Scoreboard bench for phase_scheduler. The stimulus process drives inputs,
// advances a behavioural model of the intersection rules and queues the
// outputs expected after each clock edge. An independent monitor pops one
// expectation per cycle on the falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_phase_scheduler;

   localparam int MIN_G  = 3;
   localparam int MAX_G  = 6;
   localparam int YEL    = 2;
   localparam int ALLRED = 1;
   localparam int WALK_D = 4;

   // Phase codes used by the model
   localparam int P_MAIN_G = 0, P_MAIN_Y = 1, P_CLEAR = 2;
   localparam int P_SIDE_G = 3, P_SIDE_Y = 4, P_WALK = 5;

   logic       clk;
   logic       reset, tick, req_side, req_ped;
   logic       g_main, y_main, r_main, g_side, y_side, r_side;
   logic       g_pedes, r_pedes, ped_wait;
   logic [2:0] phase;

   phase_scheduler #(
      .MIN_GREEN (MIN_G),
      .MAX_GREEN (MAX_G),
      .YELLOW_T  (YEL),
      .ALL_RED_T (ALLRED),
      .WALK_T    (WALK_D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .req_side (req_side),
      .req_ped  (req_ped),
      .g_main   (g_main),
      .y_main   (y_main),
      .r_main   (r_main),
      .g_side   (g_side),
      .y_side   (y_side),
      .r_side   (r_side),
      .g_pedes  (g_pedes),
      .r_pedes  (r_pedes),
      .ped_wait (ped_wait),
      .phase    (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural model: phase, ticks spent in it, latched requests,
   // where the clearance leads, and who was served most recently.
   // ------------------------------------------------------------------
   int m_phase;
   int m_ticks;
   bit m_ped, m_side, m_serve, m_last_walk;

   function automatic void model_step(input bit r, input bit t,
                                      input bit rs, input bit rp);
      int  nxt;
      bit  serve_n;
      bit  this_is_last;
      int  dur;
      if (r) begin
         m_phase = P_MAIN_G; m_ticks = 0;
         m_ped = 0; m_side = 0; m_serve = 0; m_last_walk = 0;
         return;
      end
      nxt     = m_phase;
      serve_n = m_serve;
      if (t) begin
         // This tick is tick number m_ticks+1 in the current phase.
         dur = m_ticks + 1;
         case (m_phase)
            P_MAIN_G: if (dur >= MIN_G && (m_ped || m_side)) nxt = P_MAIN_Y;
            P_MAIN_Y: if (dur == YEL) begin nxt = P_CLEAR; serve_n = 1; end
            P_CLEAR: if (dur == ALLRED) begin
               if (!m_serve) nxt = P_MAIN_G;
               else if (m_ped && m_side) nxt = m_last_walk ? P_SIDE_G : P_WALK;
               else if (m_ped) nxt = P_WALK;
               else if (m_side) nxt = P_SIDE_G;
               else nxt = P_MAIN_G;
            end
            P_SIDE_G: if (dur == MAX_G || (dur >= MIN_G && (!rs || m_ped)))
               nxt = P_SIDE_Y;
            P_SIDE_Y: if (dur == YEL) begin nxt = P_CLEAR; serve_n = 0; end
            P_WALK:   if (dur == WALK_D) begin nxt = P_CLEAR; serve_n = 0; end
            default:  nxt = P_MAIN_G;
         endcase
      end
      this_is_last = 0;
      if (nxt == P_WALK && m_phase != P_WALK) begin
         m_ped = rp; m_last_walk = 1;
      end else begin
         m_ped = m_ped | rp;
      end
      if (nxt == P_SIDE_G && m_phase != P_SIDE_G) begin
         m_side = rs; m_last_walk = 0;
      end else begin
         m_side = m_side | rs;
      end
      if (nxt != m_phase) m_ticks = 0;
      else if (t && m_ticks < 255) m_ticks = m_ticks + 1;
      m_phase = nxt;
      m_serve = serve_n;
      if (this_is_last) m_serve = 0;
   endfunction

   // Expected observable word: phase, 8 lamps, ped_wait
   function automatic logic [11:0] expect_word(input int ph, input bit pw);
      logic [7:0] lamps;
      lamps[7] = (ph == P_MAIN_G);                         // g_main
      lamps[6] = (ph == P_MAIN_Y);                         // y_main
      lamps[5] = (ph >= P_CLEAR);                          // r_main
      lamps[4] = (ph == P_SIDE_G);                         // g_side
      lamps[3] = (ph == P_SIDE_Y);                         // y_side
      lamps[2] = !(ph == P_SIDE_G || ph == P_SIDE_Y);      // r_side
      lamps[1] = (ph == P_WALK);                           // g_pedes
      lamps[0] = (ph != P_WALK);                           // r_pedes
      return {3'(ph), lamps, pw};
   endfunction

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   logic [11:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          last_exp_ph = -1;
   logic [11:0] mon_exp, mon_act;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {phase, g_main, y_main, r_main, g_side, y_side, r_side,
                    g_pedes, r_pedes, ped_wait};
         vectors++;
         if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL outputs @%0t: got phase=%0d lamps=%b ped_wait=%b, expected phase=%0d lamps=%b ped_wait=%b",
                     $time, mon_act[11:9], mon_act[8:1], mon_act[0],
                     mon_exp[11:9], mon_exp[8:1], mon_exp[0]);
         end
         if (int'(mon_exp[11:9]) != last_exp_ph) begin
            $display("t=%0t phase -> %0d (ped_wait=%b)", $time, mon_exp[11:9], mon_exp[0]);
            last_exp_ph = int'(mon_exp[11:9]);
         end
      end
   end

   // One clock of stimulus; tick strobes every 4th clock.
   task automatic step(input bit r, input bit rs, input bit rp);
      bit t;
      logic [11:0] e;
      t = (cyc % 4 == 3);
      reset    = r;
      tick     = t;
      req_side = rs;
      req_ped  = rp;
      model_step(r, t, rs, rp);
      e = expect_word(m_phase, m_ped);
      @(posedge clk);
      exp_q.push_back(e);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
   endtask

   // Step idle until the model reaches a phase; an expired bound is a failure.
   task automatic run_until(input int ph, input int limit, input bit rs);
      int k;
      k = 0;
      while (m_phase != ph && k < limit) begin
         step(0, rs, 0);
         k++;
      end
      if (m_phase != ph) begin
         miscompares++;
         $display("FAIL wait_phase: phase %0d not reached in %0d cycles, got model phase %0d",
                  ph, limit, m_phase);
      end
   endtask

   initial begin
      bit hold_side;
      reset = 1'b1; tick = 1'b0; req_side = 1'b0; req_ped = 1'b0;

      // Idle: 50 ticks with no requests
      do_reset(3);
      idle(200);

      // Pedestrian serve from a one-cycle pulse just after reset
      do_reset(2);
      step(0, 0, 1);
      idle(60);

      // Round robin: both requested together, walk first then side
      do_reset(2);
      step(0, 1, 1);
      idle(120);

      // Side max green: detector held high
      do_reset(2);
      for (int i = 0; i < 120; i++) step(0, 1, 0);
      idle(40);

      // Side min green with a pedestrian press during SIDE_G
      do_reset(2);
      step(0, 1, 0);
      run_until(P_SIDE_G, 100, 1'b0);
      step(0, 1, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 0);
      idle(80);

      // Reset in the middle of WALK
      do_reset(2);
      step(0, 0, 1);
      run_until(P_WALK, 100, 1'b0);
      idle(5);
      step(1, 0, 0);
      idle(40);

      // Randomized traffic
      hold_side = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) hold_side = ~hold_side;
         if ($urandom_range(0, 799) == 0)
            step(1, hold_side, 0);
         else
            step(0, hold_side, $urandom_range(0, 59) == 0);
      end
      idle(4);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
